// File: rtl/cmd_arb_bridge_pkg.sv
// Shared types and helpers for cmd_arb_bridge: FSM state encoding and the
// round-robin grant search.
package cmd_arb_bridge_pkg;

  localparam int unsigned MAX_CH  = 8;
  localparam int unsigned GRANT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // First requesting channel after last, wrapping over num_ch channels.
  function automatic logic [GRANT_W-1:0] rr_next(
    input logic [MAX_CH-1:0]  req,
    input logic [GRANT_W-1:0] last,
    input int unsigned        num_ch
  );
    logic [GRANT_W-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      idx = (32'(last) + i) % num_ch;
      if (!found && (i <= num_ch) && req[idx[GRANT_W-1:0]]) begin
        pick  = idx[GRANT_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cmd_chan_fifo.sv
// Per-channel first-word-fall-through command buffer; writes into a full
// buffer are dropped, even when a read happens in the same cycle.
module cmd_chan_fifo #(
  parameter int unsigned WIDTH = 57,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  logic             push;
  logic             pop;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    count_nx = count;
    if (push && !pop) begin
      count_nx = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nx = count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nx;
      full  <= (count_nx == CNT_W'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/cmd_arb_bridge.sv
// Multi-channel command bridge: buffers each upstream channel, arbitrates
// round-robin, runs one downstream transaction at a time and routes the ack
// back. Optional ack timeout is enabled by CMD_ARB_BRIDGE_TIMEOUT_EN.
module cmd_arb_bridge
  import cmd_arb_bridge_pkg::*;
#(
  parameter int unsigned          NUM_CH         = 2,
  parameter int unsigned          ADDR_BITS      = 24,
  parameter int unsigned          DATA_BITS      = 32,
  parameter int unsigned          FIFO_DEPTH     = 4,
  parameter int unsigned          TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_BITS-1:0] ERR_DATA       = DATA_BITS'(32'hDEAD_BEEF)
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_rst_n,
  input  logic [NUM_CH-1:0]             i_cmd_sel,
  input  logic [NUM_CH-1:0]             i_cmd_rd_wr_n,
  input  logic [NUM_CH*ADDR_BITS-1:0]   i_cmd_byte_addr,
  input  logic [NUM_CH*DATA_BITS-1:0]   i_cmd_wdata,
  output logic [NUM_CH-1:0]             o_cmd_ack,
  output logic [NUM_CH*DATA_BITS-1:0]   o_cmd_rdata,
  output logic [NUM_CH-1:0]             o_cmd_ovf,
  output logic                          o_sys_sel,
  output logic                          o_sys_rd_wr_n,
  output logic [ADDR_BITS-1:0]          o_sys_byte_addr,
  output logic [DATA_BITS-1:0]          o_sys_wdata,
  input  logic                          i_sys_ack,
  input  logic [DATA_BITS-1:0]          i_sys_rdata,
  output logic                          o_timeout,
  output logic                          o_busy
);

  typedef struct packed {
    logic                 rd_wr_n;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
  } cmd_word_t;

  localparam int unsigned CMD_W = $bits(cmd_word_t);

  cmd_word_t            fifo_dout [NUM_CH];
  logic [NUM_CH-1:0]    fifo_full;
  logic [NUM_CH-1:0]    fifo_empty;
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    pop;

  state_t               state_q;
  state_t               state_d;
  logic [GRANT_W-1:0]   grant_q;
  logic [GRANT_W-1:0]   grant_d;
  logic                 cmd_ld;
  cmd_word_t            cmd_d;
  logic                 sys_sel_d;
  logic                 resp_ld;
  logic [DATA_BITS-1:0] resp_data;
  logic [NUM_CH-1:0]    ack_d;
  logic                 busy_d;

`ifdef CMD_ARB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0]      cnt_q;
  logic [TO_W-1:0]      cnt_d;
  logic                 timeout_d;
`endif

  // One buffer per upstream channel
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CMD_W-1:0] din;
    logic [CMD_W-1:0] dout;

    assign din = {i_cmd_rd_wr_n[c],
                  i_cmd_byte_addr[c*ADDR_BITS +: ADDR_BITS],
                  i_cmd_wdata[c*DATA_BITS +: DATA_BITS]};

    cmd_chan_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (i_sys_clk),
      .rst_n     (i_sys_rst_n),
      .wr_en     (i_cmd_sel[c]),
      .wr_data   (din),
      .rd_en     (pop[c]),
      .rd_data_c (dout),
      .full      (fifo_full[c]),
      .empty     (fifo_empty[c])
    );

    assign fifo_dout[c] = dout;
  end

  assign req = ~fifo_empty;

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cmd_ld    = 1'b0;
    cmd_d     = '0;
    sys_sel_d = 1'b0;
    resp_ld   = 1'b0;
    resp_data = i_sys_rdata;
    pop       = '0;
    ack_d     = '0;
`ifdef CMD_ARB_BRIDGE_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d   = rr_next(MAX_CH'(req), grant_q, NUM_CH);
          cmd_ld    = 1'b1;
          sys_sel_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
`ifdef CMD_ARB_BRIDGE_TIMEOUT_EN
        cnt_d = cnt_q + TO_W'(1);
`endif
        if (i_sys_ack) begin
          resp_ld = 1'b1;
          state_d = RESP;
        end
`ifdef CMD_ARB_BRIDGE_TIMEOUT_EN
        // An ack in the final counted cycle takes priority over the timeout.
        else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          resp_ld   = 1'b1;
          resp_data = ERR_DATA;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]   = cmd_ld && (grant_d == GRANT_W'(c));
      ack_d[c] = resp_ld && (grant_q == GRANT_W'(c));
      if (grant_d == GRANT_W'(c)) cmd_d = fifo_dout[c];
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q         <= IDLE;
      grant_q         <= GRANT_W'(NUM_CH - 1);
      o_sys_sel       <= 1'b0;
      o_sys_rd_wr_n   <= 1'b0;
      o_sys_byte_addr <= '0;
      o_sys_wdata     <= '0;
      o_cmd_ack       <= '0;
      o_cmd_rdata     <= '0;
      o_cmd_ovf       <= '0;
      o_busy          <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      o_sys_sel <= sys_sel_d;
      o_cmd_ack <= ack_d;
      o_busy    <= busy_d;
      o_cmd_ovf <= o_cmd_ovf | (i_cmd_sel & fifo_full);
      if (cmd_ld) begin
        o_sys_rd_wr_n   <= cmd_d.rd_wr_n;
        o_sys_byte_addr <= cmd_d.addr;
        o_sys_wdata     <= cmd_d.wdata;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (ack_d[c]) o_cmd_rdata[c*DATA_BITS +: DATA_BITS] <= resp_data;
      end
    end
  end

`ifdef CMD_ARB_BRIDGE_TIMEOUT_EN
  // Counter is held at zero outside WAIT so every wait starts fresh.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      cnt_q     <= '0;
      o_timeout <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      o_timeout <= timeout_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, TIMEOUT_CYCLES};
  assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_arb_bridge.sv
// Directed bench for cmd_arb_bridge with a queue-based scoreboard; the
// timeout scenario follows CMD_ARB_BRIDGE_TIMEOUT_EN.
module tb_cmd_arb_bridge;

  localparam int unsigned NUM_CH         = 2;
  localparam int unsigned ADDR_BITS      = 24;
  localparam int unsigned DATA_BITS      = 32;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam logic [31:0] ERR_DATA       = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd_sel = '0;
  logic [1:0]  cmd_rd_wr_n = '0;
  logic [47:0] cmd_byte_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic [1:0]  cmd_ack;
  logic [63:0] cmd_rdata;
  logic [1:0]  cmd_ovf;
  logic        sys_sel;
  logic        sys_rd_wr_n;
  logic [23:0] sys_byte_addr;
  logic [31:0] sys_wdata;
  logic        sys_ack = 1'b0;
  logic [31:0] sys_rdata = '0;
  logic        timeout;
  logic        busy;

  always #5 clk = ~clk;

  cmd_arb_bridge #(
    .NUM_CH         (NUM_CH),
    .ADDR_BITS      (ADDR_BITS),
    .DATA_BITS      (DATA_BITS),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .ERR_DATA       (ERR_DATA)
  ) dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .i_cmd_sel       (cmd_sel),
    .i_cmd_rd_wr_n   (cmd_rd_wr_n),
    .i_cmd_byte_addr (cmd_byte_addr),
    .i_cmd_wdata     (cmd_wdata),
    .o_cmd_ack       (cmd_ack),
    .o_cmd_rdata     (cmd_rdata),
    .o_cmd_ovf       (cmd_ovf),
    .o_sys_sel       (sys_sel),
    .o_sys_rd_wr_n   (sys_rd_wr_n),
    .o_sys_byte_addr (sys_byte_addr),
    .o_sys_wdata     (sys_wdata),
    .i_sys_ack       (sys_ack),
    .i_sys_rdata     (sys_rdata),
    .o_timeout       (timeout),
    .o_busy          (busy)
  );

  typedef struct packed {
    logic        rw;
    logic [23:0] addr;
    logic [31:0] wdata;
  } iss_t;

  typedef struct packed {
    logic [2:0]  ch;
    logic [31:0] data;
    logic        to;
  } ack_t;

  iss_t exp_iss[$];
  ack_t exp_ack[$];
  int   total = 0;
  int   bad = 0;
  int   n_issue = 0;
  int   n_ack = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every downstream issue and upstream ack with the queues
  always @(negedge clk) begin
    iss_t e;
    ack_t a;
    if (rst_n) begin
      if (sys_sel) begin
        n_issue++;
        if (exp_iss.size() == 0) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          e = exp_iss.pop_front();
          chk("issue_rw", sys_rd_wr_n, e.rw);
          chk("issue_addr", sys_byte_addr, e.addr);
          chk("issue_wdata", sys_wdata, e.wdata);
        end
      end
      if (cmd_ack != 2'b00) begin
        n_ack++;
        if (exp_ack.size() == 0) begin
          chk("unexpected_ack", cmd_ack, 0);
        end else begin
          a = exp_ack.pop_front();
          chk("ack_channel", cmd_ack, 2'b01 << a.ch);
          chk("ack_rdata", cmd_rdata[a.ch*32 +: 32], a.data);
          chk("ack_timeout_flag", timeout, a.to);
        end
      end else if (timeout) begin
        chk("stray_timeout", 1, 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_issue(input logic rw, input logic [23:0] addr, input logic [31:0] wd);
    exp_iss.push_back(iss_t'{rw: rw, addr: addr, wdata: wd});
  endtask

  // Strobe sel for one cycle; ends one step after the sampling edge
  task automatic send(input logic [1:0] mask, input logic [1:0] rw,
                      input logic [23:0] a0, input logic [23:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    cmd_sel       = mask;
    cmd_rd_wr_n   = rw;
    cmd_byte_addr = {a1, a0};
    cmd_wdata     = {d1, d0};
    @(posedge clk);
    #1;
    cmd_sel = '0;
  endtask

  // Wait (bounded) for o_sys_sel; returns in the first WAIT cycle
  task automatic wait_issue();
    int k;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (sys_sel) break;
      k++;
    end
    chk("issue_seen", (k < 100), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ack(input logic [31:0] d, input logic [2:0] ch);
    exp_ack.push_back(ack_t'{ch: ch, data: d, to: 1'b0});
    sys_ack   = 1'b1;
    sys_rdata = d;
    @(posedge clk);
    #1;
    sys_ack   = 1'b0;
    sys_rdata = '0;
  endtask

  task automatic slave_resp(input int d, input logic [31:0] data, input logic [2:0] ch);
    wait_issue();
    step(d - 1);
    drive_ack(data, ch);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sys_sel"}, sys_sel, 0);
    chk({tag, "_cmd_ack"}, cmd_ack, 0);
    chk({tag, "_cmd_rdata"}, cmd_rdata, 0);
    chk({tag, "_cmd_ovf"}, cmd_ovf, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_sys_addr"}, sys_byte_addr, 0);
    chk({tag, "_sys_wdata"}, sys_wdata, 0);
    chk({tag, "_sys_rw"}, sys_rd_wr_n, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    cmd_sel = '0;
    sys_ack = 1'b0;
    #2;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic drain(input string tag, input int n);
    step(n);
    chk({tag, "_iss_queue_left"}, exp_iss.size(), 0);
    chk({tag, "_ack_queue_left"}, exp_ack.size(), 0);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int a0;
    int errs;

    // Single read on ch0: issue two cycles after sel, ack three cycles after issue
    do_reset();
    expect_issue(1'b1, 24'h000100, 32'h0);
    send(2'b01, 2'b01, 24'h000100, 24'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_no_early_issue", sys_sel, 0);
    @(negedge clk);
    chk("t1_issue_latency", sys_sel, 1);
    @(posedge clk);
    #1;
    step(2);
    drive_ack(32'h1234_5678, 3'd0);
    @(negedge clk);
    chk("t1_ack_latency", cmd_ack, 2'b01);
    chk("t1_busy_in_resp", busy, 1);
    @(posedge clk);
    #1;
    drain("t1", 3);

    // ch0+ch1 together, then ch0 again: order ch0, ch1, ch0
    do_reset();
    expect_issue(1'b0, 24'h000010, 32'h0000_00A0);
    expect_issue(1'b1, 24'h000020, 32'h0);
    expect_issue(1'b1, 24'h000030, 32'h0);
    send(2'b11, 2'b10, 24'h000010, 24'h000020, 32'h0000_00A0, 32'h0);
    send(2'b01, 2'b01, 24'h000030, 24'h0, 32'h0, 32'h0);
    slave_resp(1, 32'h1111_0000, 3'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_reissue_gap", sys_sel, 0);
    @(negedge clk);
    chk("t2_reissue_earliest", sys_sel, 1);
    @(posedge clk);
    #1;
    step(1);
    drive_ack(32'h2222_0001, 3'd1);
    slave_resp(1, 32'h3333_0002, 3'd0);
    drain("t2", 4);

    // Overflow: ch1 fills while a ch0 transaction stalls the bridge
    do_reset();
    n0 = n_issue;
    expect_issue(1'b0, 24'h0000B0, 32'h0000_B0B0);
    send(2'b01, 2'b00, 24'h0000B0, 24'h0, 32'h0000_B0B0, 32'h0);
    wait_issue();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_issue(1'b1, 24'h000100 + 24'(i), 32'h0);
      send(2'b10, 2'b10, 24'h0, 24'h000100 + 24'(i), 32'h0, 32'h0);
      if (i == 3) chk("t3_no_ovf_at_full", cmd_ovf, 2'b00);
    end
    chk("t3_ovf_set", cmd_ovf, 2'b10);
    drive_ack(32'hC0DE_0000, 3'd0);
    for (int i = 0; i < 4; i++) begin
      slave_resp(1, 32'hC100_0000 + 32'(i), 3'd1);
    end
    drain("t3", 6);
    chk("t3_issue_count", n_issue - n0, 5);
    chk("t3_ovf_sticky", cmd_ovf, 2'b10);

`ifdef CMD_ARB_BRIDGE_TIMEOUT_EN
    // Timeout after 16 WAIT cycles, late ack ignored, then ack on the last cycle wins
    do_reset();
    a0 = n_ack;
    expect_issue(1'b1, 24'h000044, 32'h0);
    send(2'b10, 2'b10, 24'h0, 24'h000044, 32'h0, 32'h0);
    wait_issue();
    exp_ack.push_back(ack_t'{ch: 3'd1, data: ERR_DATA, to: 1'b1});
    step(15);
    @(negedge clk);
    chk("t4_no_early_timeout", timeout, 0);
    @(negedge clk);
    chk("t4_timeout_pulse", timeout, 1);
    chk("t4_timeout_ack", cmd_ack, 2'b10);
    chk("t4_timeout_rdata", cmd_rdata[63:32], ERR_DATA);
    @(posedge clk);
    #1;
    step(4);
    sys_ack   = 1'b1;
    sys_rdata = 32'h0BAD_0BAD;
    step(1);
    sys_ack   = 1'b0;
    sys_rdata = '0;
    step(5);
    chk("t4_late_ack_ignored", n_ack - a0, 1);
    expect_issue(1'b1, 24'h000048, 32'h0);
    send(2'b10, 2'b10, 24'h0, 24'h000048, 32'h0, 32'h0);
    slave_resp(16, 32'h600D_F00D, 3'd1);
    drain("t4", 4);
`else
    // No timeout: bridge waits indefinitely, then a normal ack completes it
    do_reset();
    expect_issue(1'b1, 24'h000044, 32'h0);
    send(2'b10, 2'b10, 24'h0, 24'h000044, 32'h0, 32'h0);
    wait_issue();
    errs = 0;
    repeat (2000) begin
      @(negedge clk);
      if (!busy || cmd_ack != 2'b00 || timeout) errs++;
    end
    chk("t4_stall_busy_no_ack", errs, 0);
    @(posedge clk);
    #1;
    drive_ack(32'h5A5A_5A5A, 3'd1);
    drain("t4", 4);
`endif

    // Reset during WAIT with two queued commands: all cleared, nothing issues
    n0 = n_issue;
    expect_issue(1'b1, 24'h000070, 32'h0);
    send(2'b01, 2'b01, 24'h000070, 24'h0, 32'h0, 32'h0);
    wait_issue();
    send(2'b11, 2'b11, 24'h000071, 24'h000072, 32'h0, 32'h0);
    rst_n = 1'b0;
    #2;
    chk_zero("t5_mid_reset");
    step(2);
    #3;
    rst_n = 1'b1;
    step(30);
    chk("t5_no_issue_after", n_issue - n0, 1);
    drain("t5", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
